// File: rtl/dt_request_arbiter.sv
// Round-robin front end that shares one decision-tree classifier among NUM_REQ feature sources,
// with a launch/wait/respond handshake, timeout recovery and late-done suppression.
module dt_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SRC_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*74-1:0] req_feat,
    output logic                 dt_start,
    output logic [10:0]          dt_arb_id_dec,
    output logic [3:0]           dt_data_length,
    output logic [7:0]           dt_first_byte,
    output logic [7:0]           dt_last_byte,
    output logic [10:0]          dt_byte_sum,
    output logic [31:0]          dt_time_delta,
    input  logic                 dt_done,
    input  logic                 dt_is_attack,
    input  logic [7:0]           dt_final_node,
    input  logic                 dt_error,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SRC_W-1:0]     res_src,
    output logic                 res_is_attack,
    output logic [7:0]           res_final_node,
    output logic                 res_error,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [15:0]          timeout_count
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  grant_sel;
    logic [SRC_W-1:0]  cand;
    logic              grant_found;
    logic              accept;
    logic [15:0]       cnt;
    logic              cnt_expire;
    logic              timeout_now;
    logic              stale;
    logic [73:0]       sel_feat;

    // Walking the offsets downward lets the lowest offset from rr_ptr overwrite the others.
    always_comb begin
        grant_sel   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = SRC_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_found = 1'b1;
                grant_sel   = cand;
            end
        end
    end

    assign accept      = (state == IDLE) && !stale && grant_found;
    assign sel_feat    = req_feat[74*grant_sel +: 74];
    assign cnt_expire  = ({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);
    assign timeout_now = (state == WAIT) && !dt_done && cnt_expire;
    assign dt_start    = (state == LAUNCH);
    assign res_valid   = (state == RESP);
    assign busy        = (state != IDLE) || stale;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (dt_done || cnt_expire) state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt holds cycles elapsed since dt_start while waiting, and is reused to age out a stale launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            grant          <= '0;
            cnt            <= '0;
            stale          <= 1'b0;
            dt_arb_id_dec  <= '0;
            dt_data_length <= '0;
            dt_first_byte  <= '0;
            dt_last_byte   <= '0;
            dt_byte_sum    <= '0;
            dt_time_delta  <= '0;
            res_src        <= '0;
            res_is_attack  <= 1'b0;
            res_final_node <= '0;
            res_error      <= 1'b0;
            res_timeout    <= 1'b0;
            timeout_count  <= '0;
        end else begin
            if (accept) begin
                grant          <= grant_sel;
                dt_arb_id_dec  <= sel_feat[73:63];
                dt_data_length <= sel_feat[62:59];
                dt_first_byte  <= sel_feat[58:51];
                dt_last_byte   <= sel_feat[50:43];
                dt_byte_sum    <= sel_feat[42:32];
                dt_time_delta  <= sel_feat[31:0];
            end

            if (state == LAUNCH) begin
                cnt <= 16'd1;
            end else if (timeout_now) begin
                cnt <= '0;
            end else if ((state == WAIT) || stale) begin
                cnt <= cnt + 16'd1;
            end

            if (timeout_now) begin
                stale <= 1'b1;
            end else if (stale && (dt_done || cnt_expire)) begin
                stale <= 1'b0;
            end

            if ((state == WAIT) && dt_done) begin
                res_src        <= grant;
                res_is_attack  <= dt_is_attack;
                res_final_node <= dt_final_node;
                res_error      <= dt_error;
                res_timeout    <= 1'b0;
            end else if (timeout_now) begin
                res_src        <= grant;
                res_is_attack  <= 1'b0;
                res_final_node <= 8'hFF;
                res_error      <= 1'b1;
                res_timeout    <= 1'b1;
                if (timeout_count != 16'hFFFF) begin
                    timeout_count <= timeout_count + 16'd1;
                end
            end

            if ((state == RESP) && res_ready) begin
                rr_ptr <= (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + SRC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dt_request_arbiter.sv
// Directed self-checking bench for dt_request_arbiter with four sources and a 16-cycle timeout.
module tb_dt_request_arbiter;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [295:0]  req_feat;
    logic          dt_start;
    logic [10:0]   dt_arb_id_dec;
    logic [3:0]    dt_data_length;
    logic [7:0]    dt_first_byte;
    logic [7:0]    dt_last_byte;
    logic [10:0]   dt_byte_sum;
    logic [31:0]   dt_time_delta;
    logic          dt_done;
    logic          dt_is_attack;
    logic [7:0]    dt_final_node;
    logic          dt_error;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_src;
    logic          res_is_attack;
    logic [7:0]    res_final_node;
    logic          res_error;
    logic          res_timeout;
    logic          busy;
    logic [15:0]   timeout_count;

    int checks = 0;
    int errors = 0;
    int exp_src;
    logic [10:0] exp_id [4];

    dt_request_arbiter #(.NUM_REQ(4), .SRC_W(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
        .dt_start(dt_start), .dt_arb_id_dec(dt_arb_id_dec), .dt_data_length(dt_data_length),
        .dt_first_byte(dt_first_byte), .dt_last_byte(dt_last_byte), .dt_byte_sum(dt_byte_sum),
        .dt_time_delta(dt_time_delta), .dt_done(dt_done), .dt_is_attack(dt_is_attack),
        .dt_final_node(dt_final_node), .dt_error(dt_error),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_is_attack(res_is_attack), .res_final_node(res_final_node), .res_error(res_error),
        .res_timeout(res_timeout), .busy(busy), .timeout_count(timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [73:0] make_feat(input logic [10:0] id);
        return {id, 4'h8, 8'h11, 8'h22, 11'h033, 32'hDEADBEEF};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] v, input logic rr, input logic d,
                                  input logic a, input logic e, input logic [7:0] n);
        req_valid     = v;
        res_ready     = rr;
        dt_done       = d;
        dt_is_attack  = a;
        dt_error      = e;
        dt_final_node = n;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        exp_id[0] = 11'h123;
        exp_id[1] = 11'h101;
        exp_id[2] = 11'h102;
        exp_id[3] = 11'h103;
        req_feat = {make_feat(exp_id[3]), make_feat(exp_id[2]), make_feat(exp_id[1]), make_feat(exp_id[0])};
        rst_n = 1'b0;
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        #1;
        check_output("rst_ready", 32'(req_ready), 32'h0);
        check_output("rst_start", 32'(dt_start), 32'h0);
        check_output("rst_res_valid", 32'(res_valid), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_tcount", 32'(timeout_count), 32'h0);
        check_output("rst_arb_id", 32'(dt_arb_id_dec), 32'h0);
        #10 rst_n = 1'b1;
        tick();

        $display("[TB] single request from source 0");
        apply_stimulus(4'b0001, 0, 0, 0, 0, 8'h00);
        check_output("t1_ready", 32'(req_ready), 32'h1);
        check_output("t1_no_start", 32'(dt_start), 32'h0);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t1_start", 32'(dt_start), 32'h1);
        check_output("t1_ready_off", 32'(req_ready), 32'h0);
        check_output("t1_arb_id", 32'(dt_arb_id_dec), 32'h123);
        check_output("t1_dlc", 32'(dt_data_length), 32'h8);
        check_output("t1_delta", dt_time_delta, 32'hDEADBEEF);
        req_feat[73:0] = make_feat(11'h7FF);
        repeat (9) tick();
        check_output("t1_start_once", 32'(dt_start), 32'h0);
        check_output("t1_feat_hold", 32'(dt_arb_id_dec), 32'h123);
        tick();
        apply_stimulus(4'b0000, 0, 1, 1, 0, 8'h2A);
        check_output("t1_no_res_yet", 32'(res_valid), 32'h0);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t1_res_valid", 32'(res_valid), 32'h1);
        check_output("t1_src", 32'(res_src), 32'h0);
        check_output("t1_attack", 32'(res_is_attack), 32'h1);
        check_output("t1_node", 32'(res_final_node), 32'h2A);
        check_output("t1_error", 32'(res_error), 32'h0);
        check_output("t1_timeout", 32'(res_timeout), 32'h0);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t1_res_clear", 32'(res_valid), 32'h0);
        check_output("t1_idle", 32'(busy), 32'h0);
        req_feat[73:0] = make_feat(exp_id[0]);

        $display("[TB] round robin with all sources requesting");
        for (int k = 0; k < 5; k++) begin
            exp_src = (1 + k) % 4;
            apply_stimulus(4'b1111, 1, 0, 0, 0, 8'h00);
            check_output("t2_ready", 32'(req_ready), 32'(1 << exp_src));
            tick();
            check_output("t2_start", 32'(dt_start), 32'h1);
            check_output("t2_arb_id", 32'(dt_arb_id_dec), 32'(exp_id[exp_src]));
            tick();
            apply_stimulus(4'b1111, 1, 1, k[0], 0, 8'(k + 16));
            tick();
            apply_stimulus(4'b1111, 1, 0, 0, 0, 8'h00);
            check_output("t2_res_valid", 32'(res_valid), 32'h1);
            check_output("t2_src", 32'(res_src), 32'(exp_src));
            check_output("t2_node", 32'(res_final_node), 32'(k + 16));
            check_output("t2_attack", 32'(res_is_attack), 32'(k[0]));
            tick();
        end
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);

        $display("[TB] classifier timeout and late done");
        apply_stimulus(4'b0001, 0, 0, 0, 0, 8'h00);
        check_output("t3_ready", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t3_start", 32'(dt_start), 32'h1);
        repeat (15) tick();
        check_output("t3_not_yet", 32'(res_valid), 32'h0);
        tick();
        check_output("t3_res_valid", 32'(res_valid), 32'h1);
        check_output("t3_timeout", 32'(res_timeout), 32'h1);
        check_output("t3_error", 32'(res_error), 32'h1);
        check_output("t3_node", 32'(res_final_node), 32'hFF);
        check_output("t3_attack", 32'(res_is_attack), 32'h0);
        check_output("t3_src", 32'(res_src), 32'h0);
        check_output("t3_tcount", 32'(timeout_count), 32'h1);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0010, 0, 1, 1, 0, 8'h99);
        check_output("t3_stale_block", 32'(req_ready), 32'h0);
        check_output("t3_stale_busy", 32'(busy), 32'h1);
        tick();
        apply_stimulus(4'b0010, 0, 0, 0, 0, 8'h00);
        check_output("t3_after_stale", 32'(req_ready), 32'h2);
        check_output("t3_busy_clear", 32'(busy), 32'h0);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t3_start2", 32'(dt_start), 32'h1);
        check_output("t3_arb_id2", 32'(dt_arb_id_dec), 32'h101);
        tick();
        apply_stimulus(4'b0000, 0, 1, 0, 0, 8'h33);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t3_src2", 32'(res_src), 32'h1);
        check_output("t3_node2", 32'(res_final_node), 32'h33);
        check_output("t3_timeout2", 32'(res_timeout), 32'h0);
        check_output("t3_tcount2", 32'(timeout_count), 32'h1);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);

        $display("[TB] result backpressure");
        apply_stimulus(4'b0110, 0, 0, 0, 0, 8'h00);
        check_output("t4_ready", 32'(req_ready), 32'h4);
        tick();
        check_output("t4_start", 32'(dt_start), 32'h1);
        tick();
        apply_stimulus(4'b0110, 0, 1, 1, 0, 8'h44);
        tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                apply_stimulus(4'b0110, 0, 1, 0, 1, 8'hEE);
            end else begin
                apply_stimulus(4'b0110, 0, 0, 0, 0, 8'h00);
            end
            check_output("t4_res_valid", 32'(res_valid), 32'h1);
            check_output("t4_node", 32'(res_final_node), 32'h44);
            check_output("t4_src", 32'(res_src), 32'h2);
            check_output("t4_error", 32'(res_error), 32'h0);
            check_output("t4_no_ready", 32'(req_ready), 32'h0);
            check_output("t4_no_start", 32'(dt_start), 32'h0);
            tick();
        end
        apply_stimulus(4'b0110, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0110, 0, 0, 0, 0, 8'h00);
        check_output("t4_next_grant", 32'(req_ready), 32'h2);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 1, 0, 0, 8'h55);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t4_src2", 32'(res_src), 32'h1);
        check_output("t4_node2", 32'(res_final_node), 32'h55);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);

        $display("[TB] done coincident with timeout expiry");
        apply_stimulus(4'b0001, 0, 0, 0, 0, 8'h00);
        check_output("t5_ready", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        repeat (15) tick();
        apply_stimulus(4'b0000, 0, 1, 1, 0, 8'h66);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t5_res_valid", 32'(res_valid), 32'h1);
        check_output("t5_timeout", 32'(res_timeout), 32'h0);
        check_output("t5_error", 32'(res_error), 32'h0);
        check_output("t5_node", 32'(res_final_node), 32'h66);
        check_output("t5_tcount", 32'(timeout_count), 32'h1);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t5_no_stale", 32'(busy), 32'h0);

        $display("[TB] asynchronous reset during wait");
        apply_stimulus(4'b0001, 0, 0, 0, 0, 8'h00);
        check_output("t6_ready", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_output("t6_busy", 32'(busy), 32'h0);
        check_output("t6_start", 32'(dt_start), 32'h0);
        check_output("t6_arb_id", 32'(dt_arb_id_dec), 32'h0);
        check_output("t6_tcount", 32'(timeout_count), 32'h0);
        check_output("t6_res_valid", 32'(res_valid), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        apply_stimulus(4'b0001, 0, 0, 0, 0, 8'h00);
        check_output("t6_ready2", 32'(req_ready), 32'h1);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t6_arb_id2", 32'(dt_arb_id_dec), 32'h123);
        tick();
        apply_stimulus(4'b0000, 0, 1, 0, 1, 8'h77);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t6_src", 32'(res_src), 32'h0);
        check_output("t6_node", 32'(res_final_node), 32'h77);
        check_output("t6_error", 32'(res_error), 32'h1);
        check_output("t6_timeout", 32'(res_timeout), 32'h0);
        apply_stimulus(4'b0000, 1, 0, 0, 0, 8'h00);
        tick();
        apply_stimulus(4'b0000, 0, 0, 0, 0, 8'h00);
        check_output("t6_res_clear", 32'(res_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
